// File: rtl/serial_mod_pkg.sv
// Shared types for the serial divisibility arbiter: FSM state encoding and result tag.
package serial_mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic div;
    logic id;
  } res_tag_t;

  function automatic logic [1:0] grant_onehot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mod_rem_step.sv
// One MSB-first remainder step: next = (2*rem + bit) mod DIVISOR, using a single conditional subtract.
module mod_rem_step #(
  parameter int DIVISOR = 5
) (
  input  logic [$clog2(DIVISOR)-1:0] rem_i,
  input  logic                       bit_i,
  output logic [$clog2(DIVISOR)-1:0] rem_o
);

  localparam int RW = $clog2(DIVISOR);
  localparam logic [RW:0] DIV_EXT = (RW+1)'(DIVISOR);

  logic [RW:0] dbl;

  // 2*rem+bit < 2*DIVISOR, so one subtract always lands back in range.
  always_comb begin
    dbl = {rem_i, bit_i};
    if (dbl >= DIV_EXT) begin
      rem_o = RW'(dbl - DIV_EXT);
    end else begin
      rem_o = dbl[RW-1:0];
    end
  end

endmodule

// File: rtl/serial_mod_arbiter.sv
// Round-robin arbiter in front of a shared serial divisible-by-DIVISOR checker.
// Optional MOD_REM_OUT_EN adds a res_rem port carrying the final remainder.
module serial_mod_arbiter
  import serial_mod_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_div,
  output logic             res_id
`ifdef MOD_REM_OUT_EN
  ,
  output logic [$clog2(DIVISOR)-1:0] res_rem
`endif
);

  localparam int RW = $clog2(DIVISOR);
  localparam int CW = $clog2(WIDTH+1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [RW-1:0]    rem_q, rem_d, rem_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             rr_q, rr_d;
  res_tag_t         tag_q, tag_d;
  logic             res_valid_q, res_valid_d;
`ifdef MOD_REM_OUT_EN
  logic [RW-1:0]    rem_out_q, rem_out_d;
`endif

  logic grant;
  logic accept;

  mod_rem_step #(.DIVISOR(DIVISOR)) u_step (
    .rem_i (rem_q),
    .bit_i (shreg_q[WIDTH-1]),
    .rem_o (rem_nxt)
  );

  // rr_q is the last requester served; on contention the other one wins.
  always_comb begin
    grant     = (req_valid == 2'b11) ? ~rr_q : req_valid[1];
    req_ready = 2'b00;
    if (rst && (state_q == ST_IDLE) && (|req_valid)) begin
      req_ready = grant_onehot(grant);
    end
    accept = |(req_valid & req_ready);
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    rr_d        = rr_q;
    tag_d       = tag_q;
    res_valid_d = res_valid_q;
`ifdef MOD_REM_OUT_EN
    rem_out_d   = rem_out_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = grant ? req_data1 : req_data0;
          rem_d   = '0;
          cnt_d   = '0;
          id_d    = grant;
          rr_d    = grant;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rem_d   = rem_nxt;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          tag_d.div   = (rem_nxt == '0);
          tag_d.id    = id_q;
`ifdef MOD_REM_OUT_EN
          rem_out_d   = rem_nxt;
`endif
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      rr_q        <= 1'b1;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
`ifdef MOD_REM_OUT_EN
      rem_out_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
`ifdef MOD_REM_OUT_EN
      rem_out_q   <= rem_out_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_div   = tag_q.div;
  assign res_id    = tag_q.id;
`ifdef MOD_REM_OUT_EN
  assign res_rem   = rem_out_q;
`endif

endmodule
